// File: rtl/store_write_buffer.sv
// Store write buffer between EX/MEM and the data cache.
// Committed stores are queued as {address, data, id} entries in a circular
// FIFO and drained to the d-cache in program order. Loads probe the buffer
// and receive the youngest matching store one cycle later.
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module store_write_buffer #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 20
) (
   input  logic                       clk,
   input  logic                       rst,
   // enqueue side
   input  logic                       in_valid,
   input  logic [ADDR_WIDTH-1:0]      in_addr,
   input  logic [DATA_WIDTH-1:0]      in_data,
   input  logic [ID_WIDTH-1:0]        in_id,
   output logic                       in_ready,
   // load forwarding
   input  logic                       lookup_valid,
   input  logic [ADDR_WIDTH-1:0]      lookup_addr,
   output logic                       take,
   output logic                       hit_valid,
   output logic [DATA_WIDTH-1:0]      hit_data,
   output logic [ID_WIDTH-1:0]        hit_id,
   // d-cache drain side
   output logic                       drain_valid,
   output logic [ADDR_WIDTH-1:0]      drain_addr,
   output logic [DATA_WIDTH-1:0]      drain_data,
   output logic [ID_WIDTH-1:0]        drain_id,
   input  logic                       drain_ready,
   // status
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [ID_WIDTH-1:0]   id_mem   [DEPTH];
   logic [DEPTH-1:0]      valid;

   logic [PW-1:0] head;
   logic [PW-1:0] tail;

   logic          push;
   logic          pop;
   logic          match;
   logic [PW-1:0] match_idx;

   // Status flags come straight from the occupancy counter.
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign in_ready = !full;

   // in_ready deliberately ignores drain_ready: a push into a full buffer is
   // refused even if the head drains in the same cycle.
   assign push = in_valid && !full;
   assign pop  = drain_valid && drain_ready;

   assign drain_valid = !empty;
   assign drain_addr  = addr_mem[head];
   assign drain_data  = data_mem[head];
   assign drain_id    = id_mem[head];

   // Scan from oldest to youngest so the last match seen is the youngest store.
   // NOTE: every signal assigned in always_comb gets a default first, otherwise
   // a path that skips the assignment would infer a latch.
   always_comb begin
      match     = 1'b0;
      match_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PW-1:0] idx;
         idx = head + PW'(i);
         if (valid[idx] && (addr_mem[idx] == lookup_addr)) begin
            match     = 1'b1;
            match_idx = idx;
         end
      end
   end

   // Pointer, count and per-entry valid bookkeeping.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         // push and pop never share an index: equal pointers mean empty
         // (no pop) or full (no push).
         if (push) begin
            valid[tail] <= 1'b1;
            tail        <= tail + PW'(1);
         end
         if (pop) begin
            valid[head] <= 1'b0;
            head        <= head + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry payload storage, written at tail on an accepted push.
   // NOTE: the payload arrays are intentionally not reset; the valid bits and
   // count gate every use, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[tail] <= in_addr;
         data_mem[tail] <= in_data;
         id_mem[tail]   <= in_id;
      end
   end

   // Registered lookup result; data and id hold on a miss.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         take      <= 1'b0;
         hit_valid <= 1'b0;
         hit_data  <= '0;
         hit_id    <= '0;
      end else begin
         hit_valid <= lookup_valid;
         take      <= lookup_valid && match;
         if (lookup_valid && match) begin
            hit_data <= data_mem[match_idx];
            hit_id   <= id_mem[match_idx];
         end
      end
   end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios followed by
// a randomized phase, all compared against a queue-based reference model.

module tb_store_write_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int IW    = 20;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [IW-1:0] id;
   } entry_t;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic [AW-1:0]     in_addr;
   logic [DW-1:0]     in_data;
   logic [IW-1:0]     in_id;
   logic              in_ready;
   logic              lookup_valid;
   logic [AW-1:0]     lookup_addr;
   logic              take;
   logic              hit_valid;
   logic [DW-1:0]     hit_data;
   logic [IW-1:0]     hit_id;
   logic              drain_valid;
   logic [AW-1:0]     drain_addr;
   logic [DW-1:0]     drain_data;
   logic [IW-1:0]     drain_id;
   logic              drain_ready;
   logic [$clog2(DEPTH):0] count;
   logic              full;
   logic              empty;

   store_write_buffer #(
      .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_id(in_id),
      .in_ready(in_ready),
      .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
      .take(take), .hit_valid(hit_valid), .hit_data(hit_data), .hit_id(hit_id),
      .drain_valid(drain_valid), .drain_addr(drain_addr), .drain_data(drain_data),
      .drain_id(drain_id), .drain_ready(drain_ready),
      .count(count), .full(full), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   entry_t        q[$];
   logic          m_take;
   logic          m_hv;
   logic [DW-1:0] m_hd;
   logic [IW-1:0] m_hid;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_take = 1'b0;
      m_hv   = 1'b0;
      m_hd   = '0;
      m_hid  = '0;
   endtask

   task automatic check_outputs();
      check("count",       64'(count),       64'(q.size()));
      check("empty",       64'(empty),       64'(q.size() == 0));
      check("full",        64'(full),        64'(q.size() == DEPTH));
      check("in_ready",    64'(in_ready),    64'(q.size() != DEPTH));
      check("drain_valid", 64'(drain_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         check("drain_addr", 64'(drain_addr), 64'(q[0].addr));
         check("drain_data", 64'(drain_data), 64'(q[0].data));
         check("drain_id",   64'(drain_id),   64'(q[0].id));
      end
      check("take",      64'(take),      64'(m_take));
      check("hit_valid", 64'(hit_valid), 64'(m_hv));
      check("hit_data",  64'(hit_data),  64'(m_hd));
      check("hit_id",    64'(hit_id),    64'(m_hid));
   endtask

   // One clock cycle: apply inputs, check current outputs, advance the model,
   // then step past the rising edge.
   task automatic cycle(input logic iv, input logic [AW-1:0] ia, input logic [DW-1:0] idt,
                        input logic [IW-1:0] iid, input logic lv, input logic [AW-1:0] la,
                        input logic dr);
      int  hit_pos;
      bit  was_full;
      in_valid     = iv;
      in_addr      = ia;
      in_data      = idt;
      in_id        = iid;
      lookup_valid = lv;
      lookup_addr  = la;
      drain_ready  = dr;
      #1;
      check_outputs();
      // youngest buffered store with this address, using pre-edge contents
      hit_pos = -1;
      foreach (q[i]) if (q[i].addr == la) hit_pos = i;
      if (lv && hit_pos >= 0) begin
         m_take = 1'b1;
         m_hd   = q[hit_pos].data;
         m_hid  = q[hit_pos].id;
      end else begin
         m_take = 1'b0;
      end
      m_hv     = lv;
      was_full = (q.size() == DEPTH);
      if (dr && q.size() != 0) void'(q.pop_front());
      if (iv && !was_full) q.push_back('{addr: ia, data: idt, id: iid});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic dr);
      cycle(1'b0, '0, '0, '0, 1'b0, '0, dr);
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [IW-1:0] id);
      cycle(1'b1, a, d, id, 1'b0, '0, 1'b0);
   endtask

   task automatic lookup(input logic [AW-1:0] a);
      cycle(1'b0, '0, '0, '0, 1'b1, a, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b1;
      in_valid     = 1'b0;
      in_addr      = '0;
      in_data      = '0;
      in_id        = '0;
      lookup_valid = 1'b0;
      lookup_addr  = '0;
      drain_ready  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset then idle, then a single push becomes visible next cycle
      idle(1'b0);
      push(32'h100, 32'hDEADBEEF, 20'd5);
      idle(1'b0);

      // fill to DEPTH, a fifth push is ignored, then drain in order
      push(32'h104, 32'h1111_0001, 20'd6);
      push(32'h108, 32'h1111_0002, 20'd7);
      push(32'h10C, 32'h1111_0003, 20'd8);
      push(32'h110, 32'h1111_0004, 20'd9);
      repeat (4) idle(1'b1);
      idle(1'b0);

      // youngest match wins; a miss gives take=0 with data held
      push(32'h40, 32'h11, 20'd1);
      push(32'h40, 32'h22, 20'd2);
      lookup(32'h40);
      lookup(32'h44);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);

      // full with drain_ready and in_valid together: pop only, then push accepted
      push(32'h200, 32'hA0, 20'd20);
      push(32'h204, 32'hA1, 20'd21);
      push(32'h208, 32'hA2, 20'd22);
      push(32'h20C, 32'hA3, 20'd23);
      cycle(1'b1, 32'h210, 32'hA4, 20'd24, 1'b0, '0, 1'b1);
      push(32'h214, 32'hA5, 20'd25);
      repeat (4) idle(1'b1);
      idle(1'b0);

      // lookup of the popping head forwards pre-pop data;
      // a same-cycle push is invisible to that cycle's lookup
      push(32'h300, 32'hB0, 20'd30);
      push(32'h304, 32'hB1, 20'd31);
      cycle(1'b0, '0, '0, '0, 1'b1, 32'h300, 1'b1);
      cycle(1'b1, 32'h308, 32'hB2, 20'd32, 1'b1, 32'h308, 1'b0);
      lookup(32'h308);

      // asynchronous reset with three entries buffered and take high
      push(32'h30C, 32'hB3, 20'd33);
      lookup(32'h304);
      check("pre_rst_count", 64'(count), 64'(3));
      check("pre_rst_take",  64'(take),  64'(1));
      rst = 1'b1;
      #1;
      check("rst_count",       64'(count),       64'(0));
      check("rst_empty",       64'(empty),       64'(1));
      check("rst_drain_valid", 64'(drain_valid), 64'(0));
      check("rst_take",        64'(take),        64'(0));
      check("rst_hit_valid",   64'(hit_valid),   64'(0));
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1'b0);
      push(32'h400, 32'hC0, 20'd40);
      push(32'h404, 32'hC1, 20'd41);
      lookup(32'h400);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);

      // randomized traffic over a small address set to provoke hits
      for (int n = 0; n < 400; n++) begin
         cycle(1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 7)),
               DW'($urandom),
               IW'($urandom),
               1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 7)),
               1'($urandom_range(0, 2) == 0));
      end
      repeat (DEPTH + 1) idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
